// File: rtl/mfunc_reg_arb.sv
// Round-robin arbiter sharing one MFUNC sub-register port between NUM_REQ requesters.
// Latency: request sampled in IDLE at cycle N, register access at N+1, ack + read data at N+2.
// Backpressure: req is a level held until ack; losers simply wait, at most NUM_REQ-1 transactions.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req/i_req_wr      per-requester request level and write(1)/read(0) select
//   i_req_addr/_wdata   packed per-requester address / write data, requester i at [i*W +: W]
//   o_ack               one-hot, one-cycle completion pulse
//   o_rsp_rdata         read data in the ack cycle (0 for writes), held until the next access
//   o_grant_id          current or last granted requester
//   o_busy              high during ACCESS and RESP
//   o_reg_wr_en         write strobe to the register block (ACCESS only)
//   o_sub_reg_addr      address to the register block
//   o_reg_wr_data       write data to the register block
//   i_reg_rd_data       combinational read data from the register block
module mfunc_reg_arb #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic [2:0]                o_grant_id,
  output logic                      o_busy,
  output logic                      o_reg_wr_en,
  output logic [ADDR_W-1:0]         o_sub_reg_addr,
  output logic [DATA_W-1:0]         o_reg_wr_data,
  input  logic [DATA_W-1:0]         i_reg_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Pointer starts at the top requester so requester 0 has first priority.
  localparam logic [2:0] LAST_RST = 3'(NUM_REQ - 1);

  state_t               r_state;
  logic [2:0]           r_last;
  logic [2:0]           r_grant;
  logic [NUM_REQ-1:0]   r_ack;
  logic [DATA_W-1:0]    r_rsp_rdata;
  logic [DATA_W-1:0]    r_wr_data;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_busy;
  logic                 r_wr_en;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic                 w_found;
  logic [2:0]           w_win;
  logic                 w_win_wr;
  logic [ADDR_W-1:0]    w_win_addr;
  logic [DATA_W-1:0]    w_win_wdata;

  // Rotate the request vector so bit 0 is requester (last+1) mod NUM_REQ;
  // the first set bit of the rotated vector is then the round-robin winner.
  // The shift amount is 4 bits so last+1 = 8 does not wrap for NUM_REQ = 8.
  assign w_req_dbl = {i_req, i_req};
  assign w_req_rot = NUM_REQ'(w_req_dbl >> ({1'b0, r_last} + 4'd1));

  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found = 1'b1;
        w_win   = 3'((int'(r_last) + 1 + k) % NUM_REQ);
      end
    end
  end

  // Select the winner's command fields with constant slices.
  always_comb begin
    w_win_wr    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == 3'(k)) begin
        w_win_wr    = i_req_wr[k];
        w_win_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
        w_win_wdata = i_req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_last      <= LAST_RST;
      r_grant     <= '0;
      r_ack       <= '0;
      r_rsp_rdata <= '0;
      r_wr_data   <= '0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_wr_en     <= 1'b0;
    end else begin
      r_ack   <= '0;
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_addr    <= w_win_addr;
            r_wr_data <= w_win_wdata;
            r_wr_en   <= w_win_wr;
            r_grant   <= w_win;
            r_last    <= w_win;
            r_busy    <= 1'b1;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // r_wr_en still holds the latched direction during ACCESS.
          r_rsp_rdata <= r_wr_en ? '0 : i_reg_rd_data;
          r_ack       <= NUM_REQ'(1) << r_grant;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ack          = r_ack;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_grant_id     = r_grant;
  assign o_busy         = r_busy;
  assign o_reg_wr_en    = r_wr_en;
  assign o_sub_reg_addr = r_addr;
  assign o_reg_wr_data  = r_wr_data;

endmodule
